// File: rtl/clock_counter_sequencer.sv
// clock_counter_sequencer: periodic latch/poll/read master for the
// clock counter debug device, streaming per-period counter deltas.
module clock_counter_sequencer #(
  parameter int RESP_TIMEOUT = 64,
  parameter int MAX_POLLS    = 16,
  parameter int PERIOD_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  output logic [7:0]              o_rw_address,
  output logic                    o_read_request,
  output logic                    o_write_request,
  input  logic [63:0]             i_read_data,
  input  logic                    i_output_valid,
  output logic                    o_sample_valid,
  output logic [63:0]             o_local_delta,
  output logic [63:0]             o_extern_delta,
  output logic                    o_busy,
  output logic                    o_error,
  output logic [7:0]              o_error_count
);

  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  localparam int PW = $clog2(MAX_POLLS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LATCH,
    S_GAP,
    S_POLL,
    S_RD_LOCAL,
    S_RD_EXT,
    S_PUBLISH
  } state_t;

  state_t r_state;
  state_t r_after_gap;
  state_t w_next;
  state_t w_after_gap;

  logic [PERIOD_WIDTH-1:0] r_period_cnt;
  logic [TW-1:0]           r_to_cnt;
  logic [PW-1:0]           r_poll_cnt;
  logic                    r_prev_valid;
  logic [63:0]             r_prev_local;
  logic [63:0]             r_prev_ext;
  logic [63:0]             r_cur_local;
  logic [63:0]             r_cur_ext;

  logic       w_xact;
  logic       w_tmo;
  logic       w_poll_last;
  logic       w_err;
  logic       w_rd;
  logic       w_wr;
  logic [7:0] w_addr;
  logic       w_busy;
  logic       w_sample;

  // State register; r_after_gap remembers where GAP hands off to
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_after_gap <= S_WAIT;
    end else begin
      r_state     <= w_next;
      r_after_gap <= w_after_gap;
    end
  end

  // Next-state decode, including handshake completion and error detection
  always_comb begin
    w_xact = (r_state == S_LATCH) || (r_state == S_POLL) ||
             (r_state == S_RD_LOCAL) || (r_state == S_RD_EXT);
    w_tmo  = w_xact && !i_output_valid &&
             (r_to_cnt == TW'(RESP_TIMEOUT - 1));
    w_poll_last = (r_poll_cnt == PW'(MAX_POLLS - 1));
    w_err  = w_tmo || ((r_state == S_POLL) && i_output_valid &&
             !i_read_data[0] && w_poll_last);
    w_next      = r_state;
    w_after_gap = r_after_gap;
    unique case (r_state)
      S_IDLE:    if (i_enable) w_next = S_LATCH;
      S_WAIT: begin
        if (!i_enable)
          w_next = S_IDLE;
        else if (r_period_cnt <= PERIOD_WIDTH'(1))
          w_next = S_LATCH;
      end
      S_LATCH, S_POLL, S_RD_LOCAL, S_RD_EXT:
        if (i_output_valid || w_tmo) w_next = S_GAP;
      S_GAP:     w_next = i_enable ? r_after_gap : S_IDLE;
      S_PUBLISH: w_next = S_WAIT;
      default:   w_next = S_IDLE;
    endcase
    if (w_err) begin
      w_after_gap = S_WAIT;
    end else if (i_output_valid) begin
      case (r_state)
        S_LATCH:    w_after_gap = S_POLL;
        S_POLL:     w_after_gap = i_read_data[0] ? S_RD_LOCAL : S_POLL;
        S_RD_LOCAL: w_after_gap = S_RD_EXT;
        S_RD_EXT:   w_after_gap = S_PUBLISH;
        default:    w_after_gap = r_after_gap;
      endcase
    end
  end

  // Output decode: bus controls follow the state being entered
  always_comb begin
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    w_addr = 8'd0;
    unique case (w_next)
      S_LATCH:    w_wr = 1'b1;
      S_POLL:     w_rd = 1'b1;
      S_RD_LOCAL: begin
        w_rd   = 1'b1;
        w_addr = 8'd1;
      end
      S_RD_EXT: begin
        w_rd   = 1'b1;
        w_addr = 8'd2;
      end
      default: w_rd = 1'b0;
    endcase
    w_busy   = (w_next != S_IDLE);
    w_sample = (r_state == S_PUBLISH) && r_prev_valid;
  end

  // Period, timeout and poll counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_period_cnt <= '0;
      r_to_cnt     <= '0;
      r_poll_cnt   <= '0;
    end else begin
      if ((w_next == S_LATCH) && (r_state != S_LATCH))
        r_period_cnt <= (i_period == '0) ? PERIOD_WIDTH'(1) : i_period;
      else if (r_period_cnt != '0)
        r_period_cnt <= r_period_cnt - PERIOD_WIDTH'(1);
      if (w_xact && (w_next == r_state))
        r_to_cnt <= r_to_cnt + TW'(1);
      else
        r_to_cnt <= '0;
      if (r_state == S_LATCH)
        r_poll_cnt <= '0;
      else if ((r_state == S_POLL) && i_output_valid)
        r_poll_cnt <= r_poll_cnt + PW'(1);
    end
  end

  // Counter captures and previous-sample bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cur_local  <= '0;
      r_cur_ext    <= '0;
      r_prev_local <= '0;
      r_prev_ext   <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      if ((r_state == S_RD_LOCAL) && i_output_valid)
        r_cur_local <= i_read_data;
      if ((r_state == S_RD_EXT) && i_output_valid)
        r_cur_ext <= i_read_data;
      if (r_state == S_PUBLISH) begin
        r_prev_local <= r_cur_local;
        r_prev_ext   <= r_cur_ext;
        r_prev_valid <= 1'b1;
      end else if (w_err || (w_next == S_IDLE)) begin
        r_prev_valid <= 1'b0;
      end
    end
  end

  // Registered outputs; deltas wrap modulo 2^64
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rw_address    <= '0;
      o_read_request  <= 1'b0;
      o_write_request <= 1'b0;
      o_busy          <= 1'b0;
      o_sample_valid  <= 1'b0;
      o_local_delta   <= '0;
      o_extern_delta  <= '0;
      o_error         <= 1'b0;
      o_error_count   <= '0;
    end else begin
      o_rw_address    <= w_addr;
      o_read_request  <= w_rd;
      o_write_request <= w_wr;
      o_busy          <= w_busy;
      o_sample_valid  <= w_sample;
      if (w_sample) begin
        o_local_delta  <= r_cur_local - r_prev_local;
        o_extern_delta <= r_cur_ext - r_prev_ext;
      end
      o_error <= w_err;
      if (w_err && (o_error_count != 8'hFF))
        o_error_count <= o_error_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_clock_counter_sequencer.sv
// tb_clock_counter_sequencer: randomized device model plus scoreboard
// for the clock counter sequencer.
module tb_clock_counter_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] period;
  logic [7:0]  addr;
  logic        rd;
  logic        wr;
  logic [63:0] rdata = '0;
  logic        ovalid = 1'b0;
  logic        sv;
  logic [63:0] ld;
  logic [63:0] ed;
  logic        busy;
  logic        err;
  logic [7:0]  ecnt;

  always #5 clk = ~clk;

  clock_counter_sequencer dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_enable(en),
    .i_period(period),
    .o_rw_address(addr),
    .o_read_request(rd),
    .o_write_request(wr),
    .i_read_data(rdata),
    .i_output_valid(ovalid),
    .o_sample_valid(sv),
    .o_local_delta(ld),
    .o_extern_delta(ed),
    .o_busy(busy),
    .o_error(err),
    .o_error_count(ecnt)
  );

  typedef struct {
    logic [63:0] l;
    logic [63:0] e;
  } samp_t;

  samp_t exp_q[$];
  int    err_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  // device knobs
  int          dev_lat = 1;
  bit          trail = 0;
  bit          withhold1 = 0;
  int          polls_needed = 1;
  logic [63:0] step_l = 64'd100;
  logic [63:0] step_e = 64'd150;
  logic [63:0] snap_l = '0;
  logic [63:0] snap_e = '0;

  // reference model
  logic [63:0] prev_l = '0;
  logic [63:0] prev_e = '0;
  bit          prev_ok = 0;
  bit          seq_open = 0;
  int          model_ecnt = 0;
  int          exp_kind = 0;
  logic [63:0] last_l = '0;
  logic [63:0] last_e = '0;
  bit          spacing_on = 0;
  int          last_sv_cyc = -1;
  int          wrap_hits = 0;

  // device internals
  bit armed = 1;
  int lat_cnt = 0;
  int hold = 0;
  int seq_polls = 1;
  int polls_done = 0;
  int wh_len = 0;
  bit cur_wh = 0;
  int cur_lat = 1;
  bit cur_trail = 0;

  logic       p_rd = 1'b0;
  logic       p_wr = 1'b0;
  logic [7:0] p_addr = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void note_error();
    model_ecnt = (model_ecnt < 255) ? model_ecnt + 1 : 255;
    err_q.push_back(model_ecnt);
    prev_ok  = 0;
    seq_open = 0;
    exp_kind = 0;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    err_q.delete();
    prev_ok    = 0;
    seq_open   = 0;
    model_ecnt = 0;
    exp_kind   = 0;
    last_l     = '0;
    last_e     = '0;
    polls_done = 0;
  endfunction

  // Device model: kinds 0=latch write, 1=poll, 2=read local, 3=read ext
  always @(negedge clk) begin
    int kind;
    bit ready;
    if (rst) begin
      ovalid  = 1'b0;
      hold    = 0;
      armed   = 1;
      lat_cnt = 0;
      wh_len  = 0;
    end else begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) ovalid = 1'b0;
      end
      kind = wr ? 0 : (addr == 8'd0) ? 1 : (addr == 8'd1) ? 2 : 3;
      if (!(rd || wr)) begin
        if (wh_len > 0) begin
          chk("timeout_len", 64'(wh_len), 64'd64);
          wh_len = 0;
        end
        armed   = 1;
        lat_cnt = 0;
      end else if (armed) begin
        if (lat_cnt == 0) begin
          chk("xact_kind", 64'(kind), 64'(exp_kind));
          cur_lat   = dev_lat;
          cur_trail = trail;
          cur_wh    = withhold1 && (kind == 2);
          if (cur_wh) note_error();
        end
        lat_cnt++;
        if (cur_wh) begin
          wh_len++;
        end else if (lat_cnt >= cur_lat) begin
          case (kind)
            0: begin
              chk("delta_hold_l", ld, last_l);
              chk("delta_hold_e", ed, last_e);
              if (seq_open) prev_ok = 0;
              seq_open   = 1;
              snap_l     = snap_l + step_l;
              snap_e     = snap_e + step_e;
              polls_done = 0;
              seq_polls  = polls_needed;
              rdata      = '0;
              exp_kind   = 1;
            end
            1: begin
              polls_done++;
              ready = (seq_polls > 0) && (polls_done >= seq_polls);
              rdata = {$urandom(), $urandom()};
              rdata[0] = ready;
              if (ready) exp_kind = 2;
              else if (polls_done >= 16) note_error();
              else exp_kind = 1;
            end
            2: begin
              rdata = snap_l;
              if (en) begin
                exp_kind = 3;
              end else begin
                exp_kind = 0;
                prev_ok  = 0;
                seq_open = 0;
              end
            end
            default: begin
              rdata = snap_e;
              if (prev_ok) begin
                exp_q.push_back('{l: snap_l - prev_l, e: snap_e - prev_e});
                if (prev_e == 64'hFFFF_FFFF_FFFF_FFF0 && snap_e == 64'h10)
                  wrap_hits++;
              end
              prev_l   = snap_l;
              prev_e   = snap_e;
              prev_ok  = 1;
              seq_open = 0;
              exp_kind = 0;
            end
          endcase
          armed  = 0;
          ovalid = 1'b1;
          hold   = cur_trail ? 2 : 1;
        end
      end
    end
  end

  // Monitor: protocol checks and scoreboard pops
  always @(negedge clk) begin
    samp_t s;
    int    ec;
    if (!rst) begin
      chk("rd_wr_excl", 64'(rd & wr), 64'd0);
      if ((rd || wr) && (p_rd || p_wr)) begin
        chk("addr_stable", 64'(addr), 64'(p_addr));
        chk("kind_stable", 64'(wr), 64'(p_wr));
      end
      if (sv) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got strobe l=%h e=%h, expected none",
                   ld, ed);
        end else begin
          s = exp_q.pop_front();
          chk("local_delta", ld, s.l);
          chk("extern_delta", ed, s.e);
          last_l = s.l;
          last_e = s.e;
        end
        if (spacing_on && last_sv_cyc >= 0)
          chk("sample_spacing", 64'(cyc - last_sv_cyc), 64'(period));
        last_sv_cyc = cyc;
      end
      if (err) begin
        if (err_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_error: got o_error count=%0d, expected none",
                   ecnt);
        end else begin
          ec = err_q.pop_front();
          chk("error_count", 64'(ecnt), 64'(ec));
        end
      end
    end
    p_rd   = rd;
    p_wr   = wr;
    p_addr = addr;
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 64'(addr), 64'd0);
    chk({tag, "_rd"}, 64'(rd), 64'd0);
    chk({tag, "_wr"}, 64'(wr), 64'd0);
    chk({tag, "_sv"}, 64'(sv), 64'd0);
    chk({tag, "_ld"}, ld, 64'd0);
    chk({tag, "_ed"}, ed, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_ecnt"}, 64'(ecnt), 64'd0);
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    en     = 1'b0;
    period = 32'd100;
    snap_l = {$urandom(), $urandom()};
    snap_e = {$urandom(), $urandom()};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // steady 100-cycle periods, 1-cycle device, ready on first poll
    @(posedge clk);
    #1;
    spacing_on  = 1;
    last_sv_cyc = -1;
    en          = 1'b1;
    run(560);
    spacing_on = 0;

    // ready on third poll, slower device with trailing strobe
    polls_needed = 3;
    dev_lat      = 2;
    trail        = 1;
    step_l       = {$urandom(), $urandom()};
    step_e       = {$urandom(), $urandom()};
    run(400);
    chk("ecnt_no_error", 64'(ecnt), 64'd0);

    // valid bit never set: poll exhaustion
    polls_needed = 0;
    dev_lat      = 1;
    trail        = 0;
    run(200);
    polls_needed = 1;
    run(320);
    chk("ecnt_after_polls", 64'(ecnt), 64'(model_ecnt));

    // device withholds the local-counter response
    withhold1 = 1;
    run(200);
    withhold1 = 0;
    run(320);
    chk("ecnt_after_timeout", 64'(ecnt), 64'(model_ecnt));

    // extern counter wraps through 2^64
    step_e = 64'h20;
    step_l = {$urandom(), $urandom()};
    snap_e = 64'hFFFF_FFFF_FFFF_FFB0;
    run(450);
    chk("wrap_case_reached", 64'(wrap_hits), 64'd1);

    // enable dropped during the local read
    dev_lat = 3;
    n = 0;
    while (!(rd && addr == 8'd1) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_rd_local: got no local read in %0d cycles, expected one", n);
    end
    en = 1'b0;
    run(12);
    chk("busy_after_disable", 64'(busy), 64'd0);
    chk("rd_after_disable", 64'(rd), 64'd0);
    chk("wr_after_disable", 64'(wr), 64'd0);
    chk("no_sample_pending", 64'(exp_q.size()), 64'd0);

    // period 0 behaves as 1, then a short period
    dev_lat = 1;
    period  = 32'd0;
    step_l  = {$urandom(), $urandom()};
    en      = 1'b1;
    run(150);
    period = 32'd40;
    run(300);

    // reset in the middle of a transaction
    n = 0;
    while (!(rd || wr) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midreset");
    @(posedge clk);
    #1;
    rst    = 1'b0;
    period = 32'd60;
    step_l = 64'd100;
    step_e = 64'd150;
    run(300);

    // drain: wait for one more strobe, then every expectation is consumed
    n = 0;
    while (!sv && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL wait_final_sample: got no strobe in %0d cycles, expected one", n);
    end
    @(negedge clk);
    #1;
    chk("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("final_err_q_empty", 64'(err_q.size()), 64'd0);
    chk("final_ecnt", 64'(ecnt), 64'(model_ecnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_counter_sequencer.md
Name: clock_counter_sequencer

Overview:
- Autonomous master for the register-level interface of the clock counter debug device: address, read request, write request, read data, output valid.
- Every programmed period it:
  - latches the counters (write to address 0);
  - polls address 0 until the valid bit is set;
  - reads the local counter (address 1) and the extern counter (address 2);
  - publishes per-period deltas.
- Sits beside the debug decoder so frequency ratios stream continuously without host traffic.

Parameters:
- RESP_TIMEOUT, 64, max cycles waited for i_output_valid per transaction.
- MAX_POLLS, 16, max reads of address 0 before declaring a latch failure.
- PERIOD_WIDTH, 32, width of i_period.

Ports:
- i_clk  in  1  single clock; also clocks the counter device interface.
- i_rst  in  1  synchronous, active-high reset.
- i_enable  in  1  run measurements while high.
- i_period  in  PERIOD_WIDTH  cycles between successive latch commands; 0 treated as 1.
- o_rw_address  out  8  device register address.
- o_read_request  out  1  device read request.
- o_write_request  out  1  device write request.
- i_read_data  in  64  device read data.
- i_output_valid  in  1  device transaction-complete strobe.
- o_sample_valid  out  1  one-cycle strobe; deltas updated this cycle.
- o_local_delta  out  64  local counter delta over last period.
- o_extern_delta  out  64  extern counter delta over last period.
- o_busy  out  1  high in any state other than IDLE.
- o_error  out  1  one-cycle strobe on timeout or poll exhaustion.
- o_error_count  out  8  saturating error count.

Behaviour:
- Reset (i_rst sampled high at posedge):
  - all outputs 0;
  - FSM to IDLE;
  - "previous sample valid" flag cleared;
  - period counter cleared.
- All outputs are registered.
- States: IDLE, WAIT, LATCH, GAP, POLL, RD_LOCAL, RD_EXT, PUBLISH.
- IDLE: on i_enable=1 go to LATCH.
- Period timing:
  - Period counter loads max(i_period,1) on every entry to LATCH.
  - It decrements every cycle, saturating at 0.
  - WAIT leaves for LATCH when the counter is 0.
  - Latch-to-latch spacing is therefore max(i_period, sequence length) cycles.
- Transaction rule, common to LATCH, POLL, RD_LOCAL and RD_EXT:
  - Drive address, assert exactly one request.
  - Hold both until i_output_valid=1 is sampled.
  - At that edge, capture i_read_data and deassert the request.
  - Then go to GAP for exactly 1 cycle, with requests low and i_output_valid ignored. This discards the device's trailing strobe.
  - Read and write requests are never high together.
  - Address is stable throughout a request.
- Transaction sequence:
  - LATCH: address 0, write request.
  - POLL: address 0, read request.
    - Captured bit0=1: next is RD_LOCAL.
    - bit0=0 and poll count < MAX_POLLS: GAP, then POLL again.
    - bit0=0 and MAX_POLLS reads done: error.
  - RD_LOCAL: address 1, read request.
  - RD_EXT: address 2, read request.
- Response timeout: a per-transaction cycle counter reaching RESP_TIMEOUT with no i_output_valid is an error.
- On any error:
  - drop the request;
  - pulse o_error;
  - increment o_error_count, saturating at 255;
  - clear the previous flag;
  - pass through GAP, then go to WAIT.
- PUBLISH:
  - If previous flag=1: o_local_delta = cur_local - prev_local and o_extern_delta = cur_ext - prev_ext, both modulo 2^64 (wrap gives the correct delta). Pulse o_sample_valid for one cycle.
  - If previous flag=0: no strobe.
  - In both cases store cur as prev, set the previous flag, go to WAIT.
- Deltas hold their value between strobes.
- i_enable low:
  - In WAIT: go to IDLE next cycle.
  - Mid-transaction: the outstanding handshake completes (or times out), then GAP, then IDLE. No PUBLISH.
  - The previous flag is cleared on entry to IDLE.
- Simultaneous timeout expiry and i_output_valid: valid wins.
- i_period changes take effect at the next LATCH.

Test Plan:
- Device model with 1-cycle response and valid bit set on the first poll; i_period=100; local counter +100/period, extern +150/period -> first period no strobe. Then o_sample_valid every 100 cycles with o_local_delta=100 and o_extern_delta=150. Address sequence is 0(W),0(R),1(R),2(R), with ≥1 low-request cycle between transactions.
- Valid bit set only on the 3rd poll -> three address-0 reads, then reads of 1 and 2. Deltas correct; o_error stays 0.
- Valid bit never set, MAX_POLLS=16 -> exactly 16 polls, o_error pulse, o_error_count=1. The next good period gives no strobe; the following one strobes.
- Device withholds i_output_valid on address 1 -> request drops after 64 cycles, o_error pulses. Sequencing resumes at the next period.
- Extern counter prev=0xFFFF_FFFF_FFFF_FFF0, cur=0x10 -> o_extern_delta=0x20.
- Deassert i_enable during RD_LOCAL -> transaction completes, no strobe, IDLE, o_busy=0. Asserting i_rst mid-transaction -> all outputs 0 next cycle, o_error_count=0.
